macu_vec: RTL and testbench
===========================

# macu_vec

Parametrised multi-lane signed multiply-accumulate unit for the inference datapath. Each accepted beat multiplies LANES signed activations by LANES held signed weights and sums the products. The lane sum is accumulated over a programmable number of beats. One dot-product result is emitted per group on a valid/ready output. It extends the single-lane 8-bit MAC with lane count, accumulator width, multi-beat accumulation, backpressure, clear and optional saturation.

## Interface
Parameters:
- DW, 8, signed width of each activation and weight lane
- LANES, 4, number of parallel multiply lanes (power of two, ≥1)
- AW, 24, signed accumulator/result width (must be ≥ 2*DW+log2(LANES))
- LEN_W, 8, width of the beat-count field

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- w_en  in  1  load weight register from wi this cycle
- wi  in  LANES*DW  packed signed weights, lane 0 in LSBs
- in_valid  in  1  activation beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- xi  in  LANES*DW  packed signed activations, lane 0 in LSBs
- len  in  LEN_W  beats per group, sampled on the group's first beat; 0 treated as 1
- acc_clr  in  1  synchronous abort/clear
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  AW  signed dot-product result
- out_ovf  out  1  result overflowed AW (saturation build only)

## Operation
- Weight register: loaded on w_en. A beat accepted in the same cycle as w_en uses the old weights. New weights apply from the next accepted beat.
- Pipeline advance enable: adv = !(out_valid & !out_ready). in_ready = adv, combinationally. When adv=0, every stage register and counter holds.
- S1 (accept cycle t): capture xi, the current weights, and first/last flags into input registers.
- S2 (t+1): register LANES products, each 2*DW bits signed (full signed DW×DW).
- S3 (t+2): register the sign-extended adder-tree sum, 2*DW+log2(LANES) bits.
- S4 (t+3): accumulate.
  - acc = (first ? 0 : acc) + sext(sum) at AW bits.
  - On last, load out_data/out_ovf and set out_valid.
- Beat counter: On a first beat, the counter loads max(len,1)-1; it decrements on each accepted beat. A beat is last when the count is 0. A group of len=1 is first and last in the same beat.
- len is ignored on non-first beats.
- out_valid clears on handshake unless a new last result loads in the same cycle. Back-to-back groups therefore stream at one result per group with no bubble.
- acc_clr has priority over all other activity. It clears the stage valids, beat counter, accumulator, out_valid, out_data and out_ovf, which discards the partial group and any unconsumed result. Beats offered in the acc_clr cycle are not accepted; in_ready is forced 0 that cycle. Weights are kept.
- Reset values: out_valid 0, out_data 0, out_ovf 0, in_ready 1 (after release), weights 0, counter 0, all stage valids 0.

## Timing
- Latency: the last beat accepted at edge t gives out_valid=1 after edge t+3, visible in cycle t+3.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipeline, with out_data stable, until the handshake. At most 3 beats are in flight, and none are lost or duplicated.
- Reset assertion mid-group drops everything asynchronously. Operation resumes from a fresh group.

## Configuration
- MACU_VEC_SAT_EN defined:
  - Accumulation is done at AW+1 bits and clamped to [-2^(AW-1), 2^(AW-1)-1] each beat.
  - A sticky per-group overflow flag is set on any clamp and is presented as out_ovf with the result. It resets on the group's first beat.
- MACU_VEC_SAT_EN undefined: accumulation wraps modulo 2^AW and out_ovf is tied 0.

## Test plan
- Single-beat group: weights {1,2,3,4}, xi {1,1,1,1}, len=1, accepted at cycle 0 -> out_valid cycle 3, out_data=10.
- Multi-beat group: same weights, three beats xi {1,1,1,1}, len=3, back-to-back -> one result 30 at cycle 5; no output on earlier beats. A second len=1 group follows with xi {-1,0,0,0} -> -1 at cycle 6.
- Overflow at default parameters: weights all -128, xi all -128, len=255.
  - Without macro -> out_data = -65536 (wrap), out_ovf=0.
  - With MACU_VEC_SAT_EN -> 8388607, out_ovf=1.
  - The next group gives 10 with out_ovf=0.
- Backpressure: out_ready low for 5 cycles while a result is held and further beats are streaming -> in_ready=0 and out_data stable throughout. After release, all subsequent results are correct and in order.
- Clear and weight timing:
  - acc_clr mid-group after 2 of 4 beats -> no output from the aborted group. A new len=1 group afterwards gives a correct fresh sum.
  - w_en in the same cycle as an accepted beat -> that beat uses the old weights.
- Async reset mid-stream with out_valid=1 -> out_valid, out_data and out_ovf go to 0 immediately. After release, in_ready=1.

Source files
------------

// File: rtl/macu_vec.sv
`default_nettype none
// ============================================================================
// Module      : macu_vec
// Description : Multi-lane signed multiply-accumulate unit. Each accepted beat
//               multiplies LANES signed activations by LANES held signed
//               weights, sums the products and accumulates the sum over a
//               programmable number of beats. One dot-product result is
//               presented per group on a valid/ready output.
//               Four-stage pipeline: input capture, products, adder tree,
//               accumulate/output. The whole pipeline stalls while a result
//               is held unconsumed.
// Option      : MACU_VEC_SAT_EN - saturating accumulation with a sticky
//               per-group overflow flag on out_ovf (otherwise wraps, ovf=0).
// Ports       : clk, rst_n       clock / async active-low reset
//               w_en, wi         weight register load
//               in_valid/ready   activation beat handshake, xi activations
//               len              beats per group (first beat only, 0 -> 1)
//               acc_clr          synchronous abort/clear
//               out_valid/ready  result handshake, out_data, out_ovf
// Revision    : 1.0 - initial release
// ============================================================================
module macu_vec #(
   parameter int DW    = 8,
   parameter int LANES = 4,
   parameter int AW    = 24,
   parameter int LEN_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en,
   input  logic [LANES*DW-1:0]   wi,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*DW-1:0]   xi,
   input  logic [LEN_W-1:0]      len,
   input  logic                  acc_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [AW-1:0]         out_data,
   output logic                  out_ovf
);

   localparam int C_PROD_W = 2 * DW;
   localparam int C_SUM_W  = C_PROD_W + $clog2(LANES);
   localparam int C_VEC_W  = LANES * DW;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [C_VEC_W-1:0]          wgt_q, wgt_d;
   logic [LEN_W-1:0]            cnt_q, cnt_d;

   logic                        s1_vld_q, s1_vld_d;
   logic [C_VEC_W-1:0]          s1_x_q, s1_x_d;
   logic [C_VEC_W-1:0]          s1_wgt_q, s1_wgt_d;
   logic                        s1_first_q, s1_first_d;
   logic                        s1_last_q, s1_last_d;

   logic                        s2_vld_q, s2_vld_d;
   logic [LANES*C_PROD_W-1:0]   s2_prod_q, s2_prod_d;
   logic                        s2_first_q, s2_first_d;
   logic                        s2_last_q, s2_last_d;

   logic                        s3_vld_q, s3_vld_d;
   logic signed [C_SUM_W-1:0]   s3_sum_q, s3_sum_d;
   logic                        s3_first_q, s3_first_d;
   logic                        s3_last_q, s3_last_d;

   logic signed [AW-1:0]        acc_q, acc_d;
   logic                        out_valid_q, out_valid_d;
   logic [AW-1:0]               out_data_q, out_data_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                        w_adv;
   logic                        w_accept;
   logic                        w_first_beat;
   logic [LANES*C_PROD_W-1:0]   w_prod;
   logic signed [C_SUM_W-1:0]   w_sum;
   logic signed [AW-1:0]        w_acc_base;
   logic signed [AW-1:0]        w_acc_next;

   // The pipeline only moves when no result is stuck at the output.
   assign w_adv    = !(out_valid_q && !out_ready);
   assign in_ready = w_adv && !acc_clr;
   assign w_accept = in_valid && in_ready;

   // A zero remaining count means no group is open, so the next beat opens one.
   assign w_first_beat = (cnt_q == '0);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DW-1:0] w_a;
      logic signed [DW-1:0] w_b;
      assign w_a = s1_x_q[l*DW +: DW];
      assign w_b = s1_wgt_q[l*DW +: DW];
      assign w_prod[l*C_PROD_W +: C_PROD_W] = C_PROD_W'(w_a) * C_PROD_W'(w_b);
   end

   always_comb begin
      w_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         w_sum = w_sum + C_SUM_W'($signed(s2_prod_q[l*C_PROD_W +: C_PROD_W]));
      end
   end

   assign w_acc_base = s3_first_q ? '0 : acc_q;

`ifdef MACU_VEC_SAT_EN
   localparam logic signed [AW-1:0] C_ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic signed [AW-1:0] C_ACC_MIN = {1'b1, {(AW-1){1'b0}}};

   logic                        grp_ovf_q, grp_ovf_d;
   logic                        out_ovf_q, out_ovf_d;
   logic signed [AW:0]          w_acc_wide;
   logic                        w_clamp;
   logic                        w_ovf_next;

   // One guard bit is enough: both operands already fit in AW bits.
   assign w_acc_wide = (AW+1)'(w_acc_base) + (AW+1)'(s3_sum_q);
   assign w_clamp    = w_acc_wide[AW] ^ w_acc_wide[AW-1];
   assign w_acc_next = !w_clamp       ? w_acc_wide[AW-1:0] :
                       w_acc_wide[AW] ? C_ACC_MIN : C_ACC_MAX;
   assign w_ovf_next = (s3_first_q ? 1'b0 : grp_ovf_q) | w_clamp;
   assign out_ovf    = out_ovf_q;
`else
   assign w_acc_next = w_acc_base + AW'(s3_sum_q);
   assign out_ovf    = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      wgt_d       = w_en ? wi : wgt_q;
      cnt_d       = cnt_q;
      s1_vld_d    = s1_vld_q;
      s1_x_d      = s1_x_q;
      s1_wgt_d    = s1_wgt_q;
      s1_first_d  = s1_first_q;
      s1_last_d   = s1_last_q;
      s2_vld_d    = s2_vld_q;
      s2_prod_d   = s2_prod_q;
      s2_first_d  = s2_first_q;
      s2_last_d   = s2_last_q;
      s3_vld_d    = s3_vld_q;
      s3_sum_d    = s3_sum_q;
      s3_first_d  = s3_first_q;
      s3_last_d   = s3_last_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
`ifdef MACU_VEC_SAT_EN
      grp_ovf_d   = grp_ovf_q;
      out_ovf_d   = out_ovf_q;
`endif

      if (acc_clr) begin
         s1_vld_d    = 1'b0;
         s2_vld_d    = 1'b0;
         s3_vld_d    = 1'b0;
         cnt_d       = '0;
         acc_d       = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
`ifdef MACU_VEC_SAT_EN
         grp_ovf_d   = 1'b0;
         out_ovf_d   = 1'b0;
`endif
      end else if (w_adv) begin
         // S1: capture beat; the weights used are those held before any
         // same-cycle w_en load.
         s1_vld_d = w_accept;
         if (w_accept) begin
            s1_x_d     = xi;
            s1_wgt_d   = wgt_q;
            s1_first_d = w_first_beat;
            if (w_first_beat) begin
               s1_last_d = (len <= LEN_W'(1));
               cnt_d     = (len == '0) ? '0 : len - LEN_W'(1);
            end else begin
               s1_last_d = (cnt_q == LEN_W'(1));
               cnt_d     = cnt_q - LEN_W'(1);
            end
         end

         // S2: products
         s2_vld_d   = s1_vld_q;
         s2_prod_d  = w_prod;
         s2_first_d = s1_first_q;
         s2_last_d  = s1_last_q;

         // S3: adder tree
         s3_vld_d   = s2_vld_q;
         s3_sum_d   = w_sum;
         s3_first_d = s2_first_q;
         s3_last_d  = s2_last_q;

         // S4: accumulate. With adv=1 any held result is being consumed this
         // cycle, so out_valid simply follows whether a new result loads.
         out_valid_d = s3_vld_q && s3_last_q;
         if (s3_vld_q) begin
            acc_d = w_acc_next;
`ifdef MACU_VEC_SAT_EN
            grp_ovf_d = w_ovf_next;
`endif
            if (s3_last_q) begin
               out_data_d = w_acc_next;
`ifdef MACU_VEC_SAT_EN
               out_ovf_d  = w_ovf_next;
`endif
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wgt_q       <= '0;
         cnt_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_x_q      <= '0;
         s1_wgt_q    <= '0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_vld_q    <= 1'b0;
         s2_prod_q   <= '0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         s3_vld_q    <= 1'b0;
         s3_sum_q    <= '0;
         s3_first_q  <= 1'b0;
         s3_last_q   <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef MACU_VEC_SAT_EN
         grp_ovf_q   <= 1'b0;
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         wgt_q       <= wgt_d;
         cnt_q       <= cnt_d;
         s1_vld_q    <= s1_vld_d;
         s1_x_q      <= s1_x_d;
         s1_wgt_q    <= s1_wgt_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s2_vld_q    <= s2_vld_d;
         s2_prod_q   <= s2_prod_d;
         s2_first_q  <= s2_first_d;
         s2_last_q   <= s2_last_d;
         s3_vld_q    <= s3_vld_d;
         s3_sum_q    <= s3_sum_d;
         s3_first_q  <= s3_first_d;
         s3_last_q   <= s3_last_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef MACU_VEC_SAT_EN
         grp_ovf_q   <= grp_ovf_d;
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_macu_vec.sv
`default_nettype none
// ============================================================================
// Module      : tb_macu_vec
// Description : Self-checking bench for macu_vec. Directed and random beats
//               drive a dot-product reference model; completed groups push
//               expected results into a scoreboard queue that an independent
//               monitor pops on every output handshake.
// Option      : MACU_VEC_SAT_EN selects the saturating reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_macu_vec;

   localparam int DW    = 8;
   localparam int LANES = 4;
   localparam int AW    = 24;
   localparam int LEN_W = 8;
   localparam int LW    = LANES * DW;
   localparam longint C_MAXV = (longint'(1) << (AW-1)) - 1;
   localparam longint C_MINV = -(longint'(1) << (AW-1));

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              w_en = 1'b0;
   logic [LW-1:0]     wi = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [LW-1:0]     xi = '0;
   logic [LEN_W-1:0]  len = '0;
   logic              acc_clr = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [AW-1:0]     out_data;
   logic              out_ovf;

   macu_vec #(.DW(DW), .LANES(LANES), .AW(AW), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .w_en(w_en), .wi(wi),
      .in_valid(in_valid), .in_ready(in_ready), .xi(xi), .len(len),
      .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] data;
      logic          ovf;
   } exp_t;

   exp_t   sb_q[$];
   int     checks = 0;
   int     errors = 0;

   // Reference model state: one open group at most.
   logic [LW-1:0] m_w = '0;
   bit            m_active = 1'b0;
   int            m_rem = 0;
   longint        m_acc = 0;
   bit            m_ovf = 1'b0;

   function automatic logic [LW-1:0] pk(input int a, input int b, input int c, input int d);
      logic [LW-1:0] r;
      int v[4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      r = '0;
      for (int i = 0; i < LANES && i < 4; i++) r[i*DW +: DW] = v[i][DW-1:0];
      return r;
   endfunction

   function automatic longint dot(input logic [LW-1:0] x, input logic [LW-1:0] w);
      longint s;
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
      s = 0;
      for (int l = 0; l < LANES; l++) begin
         a = x[l*DW +: DW];
         b = w[l*DW +: DW];
         s += longint'(a) * longint'(b);
      end
      return s;
   endfunction

   task automatic chk(input string nm, input longint got, input longint expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, expv);
      end
   endtask

   // Called once per cycle, after inputs settle and before the active edge.
   task automatic model_step();
      exp_t e;
      if (acc_clr) begin
         m_active = 1'b0;
         sb_q.delete();
      end else if (in_valid && in_ready) begin
         if (!m_active) begin
            m_rem    = (len == '0) ? 1 : int'(len);
            m_acc    = 0;
            m_ovf    = 1'b0;
            m_active = 1'b1;
         end
         m_acc += dot(xi, m_w);
`ifdef MACU_VEC_SAT_EN
         if (m_acc > C_MAXV) begin m_acc = C_MAXV; m_ovf = 1'b1; end
         else if (m_acc < C_MINV) begin m_acc = C_MINV; m_ovf = 1'b1; end
`endif
         m_rem--;
         if (m_rem == 0) begin
            e.data = AW'(m_acc);
            e.ovf  = m_ovf;
            sb_q.push_back(e);
            m_active = 1'b0;
         end
      end
      if (w_en) m_w = wi;
   endtask

   task automatic cycle(input bit v, input logic [LW-1:0] x, input int l, input bit we,
                        input logic [LW-1:0] w, input bit clr, input bit ordy);
      @(negedge clk);
      in_valid  = v;
      xi        = x;
      len       = LEN_W'(l);
      w_en      = we;
      wi        = w;
      acc_clr   = clr;
      out_ready = ordy;
      #1;
      model_step();
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, '0, 0, 1'b0, '0, 1'b0, ordy);
   endtask

   task automatic load_w(input logic [LW-1:0] w);
      cycle(1'b0, '0, 0, 1'b1, w, 1'b0, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 40) begin
         idle(1'b1);
         n++;
      end
      chk("drain_empty", longint'(sb_q.size()), 0);
   endtask

   // Monitor: compares every output handshake with the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected got data=%0d ovf=%0b expected no output",
                        $signed(out_data), out_ovf);
            end else begin
               e = sb_q.pop_front();
               if (out_data !== e.data || out_ovf !== e.ovf) begin
                  errors++;
                  $display("FAIL sb_result got data=%0d ovf=%0b expected data=%0d ovf=%0b",
                           $signed(out_data), out_ovf, $signed(e.data), e.ovf);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data",  longint'(out_data), 0);
      chk("rst_out_ovf",   longint'(out_ovf), 0);
      chk("rst_in_ready",  longint'(in_ready), 1);

      // ---------------- single-beat group, latency ----------------
      load_w(pk(1, 2, 3, 4));
      cycle(1'b1, pk(1, 1, 1, 1), 1, 1'b0, '0, 1'b0, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         idle(1'b1);
         chk("lat1_early_valid", longint'(out_valid), 0);
      end
      idle(1'b1);
      chk("lat1_valid", longint'(out_valid), 1);
      drain();

      // ---------------- multi-beat group followed by len=1 group ----------------
      for (int i = 0; i < 3; i++) cycle(1'b1, pk(1, 1, 1, 1), 3, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, pk(-1, 0, 0, 0), 1, 1'b0, '0, 1'b0, 1'b1);
      idle(1'b1); chk("multi_no_out_a", longint'(out_valid), 0);
      idle(1'b1); chk("multi_no_out_b", longint'(out_valid), 0);
      idle(1'b1); chk("multi_out_a",    longint'(out_valid), 1);
      idle(1'b1); chk("multi_out_b",    longint'(out_valid), 1);
      drain();

      // ---------------- w_en in the same cycle as an accepted beat ----------------
      cycle(1'b1, pk(1, 1, 1, 1), 1, 1'b1, pk(5, 5, 5, 5), 1'b0, 1'b1);
      cycle(1'b1, pk(1, 1, 1, 1), 1, 1'b0, '0, 1'b0, 1'b1);
      drain();

      // ---------------- acc_clr mid-group ----------------
      load_w(pk(1, 2, 3, 4));
      cycle(1'b1, pk(3, 3, 3, 3), 4, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, pk(3, 3, 3, 3), 4, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, pk(3, 3, 3, 3), 4, 1'b0, '0, 1'b1, 1'b0);
      repeat (5) idle(1'b1);
      chk("clr_no_out", longint'(out_valid), 0);
      cycle(1'b1, pk(2, 2, 2, 2), 1, 1'b0, '0, 1'b0, 1'b1);
      drain();

      // ---------------- backpressure ----------------
      k = 0;
      while (!out_valid && k < 20) begin
         cycle(1'b1, pk(k + 1, 1, -2, 1), 1, 1'b0, '0, 1'b0, 1'b0);
         k++;
      end
      chk("bp_result_seen", longint'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, pk(9, 9, 9, 9), 1, 1'b0, '0, 1'b0, 1'b0);
         chk("bp_in_ready", longint'(in_ready), 0);
         chk("bp_out_valid", longint'(out_valid), 1);
         if (sb_q.size() == 0) chk("bp_expect_pending", 0, 1);
         else chk("bp_out_data", longint'($signed(out_data)), longint'($signed(sb_q[0].data)));
      end
      drain();

      // ---------------- overflow group, then a normal group ----------------
      load_w(pk(-128, -128, -128, -128));
      for (int i = 0; i < 255; i++)
         cycle(1'b1, pk(-128, -128, -128, -128), 255, 1'b0, '0, 1'b0, 1'b1);
      load_w(pk(1, 2, 3, 4));
      cycle(1'b1, pk(1, 1, 1, 1), 1, 1'b0, '0, 1'b0, 1'b1);
      drain();

      // ---------------- async reset with a held result ----------------
      cycle(1'b1, pk(1, 1, 1, 1), 1, 1'b0, '0, 1'b0, 1'b0);
      k = 0;
      while (!out_valid && k < 10) begin
         idle(1'b0);
         k++;
      end
      chk("arst_result_seen", longint'(out_valid), 1);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", longint'(out_valid), 0);
      chk("arst_out_data",  longint'(out_data), 0);
      chk("arst_out_ovf",   longint'(out_ovf), 0);
      sb_q.delete();
      m_active = 1'b0;
      m_w      = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("arst_in_ready", longint'(in_ready), 1);

      // ---------------- randomized traffic ----------------
      load_w(pk(1, -2, 3, -4));
      for (int i = 0; i < 400; i++) begin
         bit v, we, clr, ordy;
         v    = ($urandom_range(0, 9) < 7);
         we   = ($urandom_range(0, 9) == 0);
         clr  = ($urandom_range(0, 49) == 0);
         ordy = clr ? 1'b0 : ($urandom_range(0, 3) != 0);
         cycle(v, LW'($urandom()), int'($urandom_range(0, 4)), we, LW'($urandom()), clr, ordy);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
